// File: rtl/pkt_router_pkg.sv
// Shared constants, types and the priority-select helper for the multicast packet router.
package pkt_router_pkg;

    localparam int PACKET_BITS_DEF  = 72;
    localparam int KEY_LSB_DEF      = 8;
    localparam int NUM_CHANNELS_DEF = 8;
    localparam int NUM_ENTRIES_DEF  = 16;
    localparam int WAIT_BITS_DEF    = 16;
    localparam int CNT_BITS_DEF     = 16;
    localparam int MAX_ENTRIES      = 64;

    typedef logic [31:0]                 key_t;
    typedef logic [NUM_CHANNELS_DEF-1:0] route_t;

    // One-hot of the lowest-index set bit; lower entries have higher priority.
    function automatic logic [MAX_ENTRIES-1:0] first_hit(input logic [MAX_ENTRIES-1:0] hits);
        logic [MAX_ENTRIES-1:0] onehot;
        logic                   found;
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (hits[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/pkt_router_lookup.sv
// Ternary key/mask table match with priority select; produces the multicast route of the winning entry.
import pkt_router_pkg::*;

module pkt_router_lookup #(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int NUM_ENTRIES  = NUM_ENTRIES_DEF
) (
    input  key_t                    key,
    input  key_t                    tbl_key   [NUM_ENTRIES],
    input  key_t                    tbl_mask  [NUM_ENTRIES],
    input  logic [NUM_CHANNELS-1:0] tbl_route [NUM_ENTRIES],
    output logic [NUM_CHANNELS-1:0] route,
    output logic                    hit
);

    logic [MAX_ENTRIES-1:0] hits_s;
    logic [MAX_ENTRIES-1:0] sel_s;

    // Per-entry ternary compare; unused upper slots stay zero.
    always_comb begin
        hits_s = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            hits_s[e] = ((key & tbl_mask[e]) == tbl_key[e]);
        end
    end

    assign sel_s = first_hit(hits_s);
    assign hit   = |hits_s;

    // Route of the single selected entry; zero on a miss.
    always_comb begin
        route = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (sel_s[e]) begin
                route = route | tbl_route[e];
            end else begin
                route = route;
            end
        end
    end

endmodule

// File: rtl/pkt_router_mc.sv
// Registered multicast packet router: holds one packet until every selected channel accepts it
// or it stalls past the drop-wait threshold, and counts delivered and dropped packets.
import pkt_router_pkg::*;

module pkt_router_mc #(
    parameter int PACKET_BITS  = PACKET_BITS_DEF,
    parameter int KEY_LSB      = KEY_LSB_DEF,
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int NUM_ENTRIES  = NUM_ENTRIES_DEF,
    parameter int WAIT_BITS    = WAIT_BITS_DEF,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             reg_key_in       [NUM_ENTRIES],
    input  logic [31:0]             reg_mask_in      [NUM_ENTRIES],
    input  logic [NUM_CHANNELS-1:0] reg_route_in     [NUM_ENTRIES],
    input  logic [WAIT_BITS-1:0]    reg_drop_wait_in,
    input  logic [PACKET_BITS-1:0]  pkt_in_data_in,
    input  logic                    pkt_in_vld_in,
    output logic                    pkt_in_rdy_out,
    output logic [PACKET_BITS-1:0]  pkt_out_data_out [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] pkt_out_vld_out,
    input  logic [NUM_CHANNELS-1:0] pkt_out_rdy_in,
    output logic [CNT_BITS-1:0]     cnt_routed_out,
    output logic [CNT_BITS-1:0]     cnt_noroute_out,
    output logic [CNT_BITS-1:0]     cnt_timeout_out
);

    localparam logic [WAIT_BITS-1:0] WAIT_ONE = {{(WAIT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic                    full_r;
    logic [PACKET_BITS-1:0]  data_r;
    logic [NUM_CHANNELS-1:0] pending_r;
    logic [WAIT_BITS-1:0]    wait_r;
    logic [CNT_BITS-1:0]     cnt_routed_r;
    logic [CNT_BITS-1:0]     cnt_noroute_r;
    logic [CNT_BITS-1:0]     cnt_timeout_r;

    logic [NUM_CHANNELS-1:0] route_s;
    logic                    hit_s;
    logic [NUM_CHANNELS-1:0] acc_s;
    logic                    done_s;
    logic                    tmo_s;
    logic                    xfer_s;
    logic                    route_zero_s;

    pkt_router_lookup #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .NUM_ENTRIES  (NUM_ENTRIES)
    ) u_lookup (
        .key       (pkt_in_data_in[KEY_LSB +: 32]),
        .tbl_key   (reg_key_in),
        .tbl_mask  (reg_mask_in),
        .tbl_route (reg_route_in),
        .route     (route_s),
        .hit       (hit_s)
    );

    assign pkt_out_vld_out = {NUM_CHANNELS{full_r}} & pending_r;
    assign acc_s           = pkt_out_vld_out & pkt_out_rdy_in;
    assign done_s          = full_r && ((pending_r & ~acc_s) == '0);
    assign tmo_s           = full_r && !done_s && (reg_drop_wait_in != '0) && (wait_r == reg_drop_wait_in);
    // Ready depends only on held state and channel readies, never on pkt_in_vld_in.
    assign pkt_in_rdy_out  = !full_r || done_s || tmo_s;
    assign xfer_s          = pkt_in_vld_in && pkt_in_rdy_out;
    assign route_zero_s    = !hit_s || (route_s == '0);

    // Broadcast the held packet to every channel.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pkt_out_data_out[c] = data_r;
        end
    end

    // Holding register: load on a routable transfer, free on done/timeout, else track progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r    <= 1'b0;
            data_r    <= '0;
            pending_r <= '0;
            wait_r    <= '0;
        end else if (xfer_s && !route_zero_s) begin
            full_r    <= 1'b1;
            data_r    <= pkt_in_data_in;
            pending_r <= route_s;
            wait_r    <= '0;
        end else if (done_s || tmo_s) begin
            full_r    <= 1'b0;
            pending_r <= '0;
            wait_r    <= '0;
        end else if (full_r) begin
            pending_r <= pending_r & ~acc_s;
            if (|acc_s) begin
                wait_r <= '0;
            end else if (wait_r != '1) begin
                wait_r <= wait_r + WAIT_ONE;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_routed_r  <= '0;
            cnt_noroute_r <= '0;
            cnt_timeout_r <= '0;
        end else begin
            if (done_s && (cnt_routed_r != '1)) begin
                cnt_routed_r <= cnt_routed_r + CNT_ONE;
            end
            if (xfer_s && route_zero_s && (cnt_noroute_r != '1)) begin
                cnt_noroute_r <= cnt_noroute_r + CNT_ONE;
            end
            if (tmo_s && (cnt_timeout_r != '1)) begin
                cnt_timeout_r <= cnt_timeout_r + CNT_ONE;
            end
        end
    end

    assign cnt_routed_out  = cnt_routed_r;
    assign cnt_noroute_out = cnt_noroute_r;
    assign cnt_timeout_out = cnt_timeout_r;

endmodule
